// File: rtl/nand_seq_pkg.sv
// ============================================================================
//  Module   : nand_seq_pkg
//  Purpose  : Shared encodings for the bit-serial NAND logic unit: operation
//             codes, FSM states, temp-register destinations and the per-op
//             step count.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package nand_seq_pkg;

  localparam logic [1:0] OP_NAND = 2'b00;
  localparam logic [1:0] OP_AND  = 2'b01;
  localparam logic [1:0] OP_OR   = 2'b10;
  localparam logic [1:0] OP_XOR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Where the output of the shared NAND cell is written on a given step.
  typedef enum logic [1:0] {
    DST_T = 2'd0,
    DST_U = 2'd1,
    DST_V = 2'd2,
    DST_R = 2'd3
  } dst_e;

  // Number of NAND evaluations needed per result bit.
  function automatic logic [2:0] steps_for(input logic [1:0] op);
    case (op)
      OP_NAND: return 3'd1;
      OP_AND:  return 3'd2;
      OP_OR:   return 3'd3;
      default: return 3'd4;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/nand_seq_alu_nand.sv
// ============================================================================
//  Module   : NAND
//  Purpose  : Two-input NAND cell, the only logic gate used for computation.
//  Ports    : in1, in2 - gate inputs
//             out      - ~(in1 & in2)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module NAND (
  input  logic in1,
  input  logic in2,
  output logic out
);

  assign out = ~(in1 & in2);

endmodule

`default_nettype wire

// File: rtl/nand_seq_alu.sv
// ============================================================================
//  Module   : nand_seq_alu
//  Purpose  : Bit-serial NAND/AND/OR/XOR unit. A single shared NAND cell is
//             sequenced over 1..4 steps per bit, LSB first.
//  Ports    : clk    - rising-edge clock
//             rst    - asynchronous active-high reset
//             start  - request, accepted only while busy is low
//             op     - 00 NAND, 01 AND, 10 OR, 11 XOR (sampled at accept)
//             a, b   - WIDTH-bit operands (sampled at accept)
//             busy   - operation in progress
//             done   - one-cycle pulse when result is updated
//             result - last completed result
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module nand_seq_alu
  import nand_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int            BW       = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       op_q;
  logic [1:0]       step_q;
  logic [BW-1:0]    bit_q;
  logic             t_q;
  logic             u_q;
  logic             v_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] result_q;
  logic             busy_q;
  logic             done_q;

  logic             w_x;
  logic             w_y;
  logic             w_in1;
  logic             w_in2;
  logic             w_r;
  dst_e             w_dst;
  logic             w_last_step;
  logic [WIDTH-1:0] w_acc_next;

  // Operand routing into the shared cell, selected by (op, step).
  always_comb begin
    w_x   = a_q[bit_q];
    w_y   = b_q[bit_q];
    w_in1 = w_x;
    w_in2 = w_y;
    w_dst = DST_R;
    case (op_q)
      OP_NAND: begin
        w_dst = DST_R;
      end
      OP_AND: begin
        if (step_q == 2'd0) begin
          w_dst = DST_T;
        end else begin
          w_in1 = t_q;
          w_in2 = t_q;
        end
      end
      OP_OR: begin
        case (step_q)
          2'd0: begin
            w_in2 = w_x;
            w_dst = DST_T;
          end
          2'd1: begin
            w_in1 = w_y;
            w_dst = DST_U;
          end
          default: begin
            w_in1 = t_q;
            w_in2 = u_q;
          end
        endcase
      end
      default: begin
        case (step_q)
          2'd0: w_dst = DST_T;
          2'd1: begin
            w_in2 = t_q;
            w_dst = DST_U;
          end
          2'd2: begin
            w_in1 = w_y;
            w_in2 = t_q;
            w_dst = DST_V;
          end
          default: begin
            w_in1 = u_q;
            w_in2 = v_q;
          end
        endcase
      end
    endcase
  end

  NAND u_nand (
    .in1 (w_in1),
    .in2 (w_in2),
    .out (w_r)
  );

  // Result bits land at their own bit position, which is equivalent to
  // shifting them in LSB first.
  always_comb begin
    w_last_step       = ({1'b0, step_q} == (steps_for(op_q) - 3'd1));
    w_acc_next        = acc_q;
    w_acc_next[bit_q] = w_r;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_NAND;
      step_q   <= 2'd0;
      bit_q    <= '0;
      t_q      <= 1'b0;
      u_q      <= 1'b0;
      v_q      <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= op;
            step_q  <= 2'd0;
            bit_q   <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= EXEC;
          end else begin
            state_q <= IDLE;
          end
        end
        EXEC: begin
          case (w_dst)
            DST_T:   t_q <= w_r;
            DST_U:   u_q <= w_r;
            DST_V:   v_q <= w_r;
            default: ;
          endcase
          if (w_last_step) begin
            step_q <= 2'd0;
            acc_q  <= w_acc_next;
            if (bit_q == LAST_BIT) begin
              result_q <= w_acc_next;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= DONE;
            end else begin
              bit_q <= bit_q + BIT_ONE;
            end
          end else begin
            step_q <= step_q + 2'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_nand_seq_alu.sv
// ============================================================================
//  Module   : tb_nand_seq_alu
//  Purpose  : Self-checking bench for nand_seq_alu (WIDTH=8) against a
//             cycle-count reference model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_nand_seq_alu;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  nand_seq_alu #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_op(input logic [1:0] o,
                                          input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    case (o)
      2'b00:   return ~(x & y);
      2'b01:   return x & y;
      2'b10:   return x | y;
      default: return x ^ y;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a request takes W*steps cycles, then the result appears
  // with a one-cycle done pulse; requests while busy are dropped.
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_result = '0;
  logic [W-1:0] m_pending = '0;
  int           m_left = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy   <= 1'b0;
      m_done   <= 1'b0;
      m_result <= '0;
      m_left   <= 0;
    end else if (m_busy) begin
      if (m_left == 1) begin
        m_result <= m_pending;
        m_done   <= 1'b1;
        m_busy   <= 1'b0;
        m_left   <= 0;
      end else begin
        m_done <= 1'b0;
        m_left <= m_left - 1;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_pending <= ref_op(op, a, b);
        m_left    <= W * (int'(op) + 1);
        m_busy    <= 1'b1;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("done", {31'd0, done}, {31'd0, m_done});
    chk("result", {24'd0, result}, {24'd0, m_result});
  end

  // Issue one request and wait for done; optionally disturb inputs mid-flight.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input bit disturb,
                        input bit use_lit, input logic [W-1:0] lit);
    int cnt;
    int lat;
    lat = W * (int'(o) + 1);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (1) begin
      @(negedge clk);
      cnt++;
      if (disturb && cnt == 3) begin
        op = 2'b11; a = 8'hFF; b = 8'hFF; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) break;
      if (cnt > 200) begin
        chk("done_timeout", 32'(cnt), 32'(lat));
        return;
      end
    end
    chk("latency", 32'(cnt), 32'(lat));
    if (use_lit) chk("literal_result", {24'd0, result}, {24'd0, lit});
    else chk("ref_result", {24'd0, result}, {24'd0, ref_op(o, x, y)});
  endtask

  initial begin
    int cnt;
    // Reset state.
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_result", {24'd0, result}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Hand-computed results for a=A5, b=3C.
    run_op(2'b00, 8'hA5, 8'h3C, 1'b0, 1'b1, 8'hDB);
    run_op(2'b01, 8'hA5, 8'h3C, 1'b0, 1'b1, 8'h24);
    run_op(2'b10, 8'hA5, 8'h3C, 1'b0, 1'b1, 8'hBD);
    run_op(2'b11, 8'hA5, 8'h3C, 1'b0, 1'b1, 8'h99);

    // Inputs changed and start pulsed while busy are ignored.
    run_op(2'b00, 8'hA5, 8'h3C, 1'b1, 1'b1, 8'hDB);
    repeat (3) @(negedge clk);

    // Reset during an XOR.
    @(negedge clk);
    op = 2'b11; a = 8'hA5; b = 8'h3C; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result", {24'd0, result}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(2'b00, 8'hFF, 8'hFF, 1'b0, 1'b1, 8'h00);

    // start held through completion: second request accepted in DONE cycle.
    @(negedge clk);
    op = 2'b01; a = 8'hA5; b = 8'h3C; start = 1'b1;
    @(negedge clk);
    op = 2'b00; a = 8'h0F; b = 8'hF0;
    cnt = 0;
    while (!done && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk("b2b_first_latency", 32'(cnt), 32'd16);
    chk("b2b_first_result", {24'd0, result}, 32'h24);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_accept_busy", {31'd0, busy}, 32'd1);
    cnt = 1;
    while (!done && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk("b2b_second_latency", 32'(cnt), 32'd9);
    chk("b2b_second_result", {24'd0, result}, 32'hFF);

    // Randomized sweep over all ops.
    for (int i = 0; i < 256; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      for (int k = 0; k < 4; k++) begin
        run_op(2'(k), ra, rb, 1'b0, 1'b0, '0);
      end
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
